stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, consecutive stable cycles required to accept a button level change.
REQ-002 SHALL have parameter TICK_DIV, default 1000000, clock cycles per count tick (100 Hz at 100 MHz).
REQ-003 SHALL have parameter SCAN_DIV, default 100000, clock cycles per display digit advance.
REQ-004 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_stop, input, 1, raw asynchronous start/stop button, active-high.
REQ-007 SHALL have port clear, input, 1, raw asynchronous clear button, active-high.
REQ-008 SHALL have port count_en, output, 1, one-cycle pulse that advances the time counter datapath.
REQ-009 SHALL have port count_clr, output, 1, one-cycle pulse that zeroes the time counter datapath.
REQ-010 SHALL have port running, output, 1, high when the state is RUN.
REQ-011 SHALL have port state, output, 2, encoding IDLE=00, RUN=01, PAUSE=10.
REQ-012 SHALL have port scan_sel, output, 2, display digit index, 0 to 3.
REQ-013 SHALL have port lap_hold, output, 1, display freeze request.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-015 SHALL change a debounced level only after the synchronized input holds the opposite value for DEB_CYCLES consecutive cycles; any mismatch restarts the count.
REQ-016 SHALL generate a one-cycle press pulse on each 0->1 debounced transition; releases and held buttons SHALL generate no pulse.
REQ-017 SHALL apply a press pulse to the FSM on the clock edge following the pulse; outputs SHALL be registered.
REQ-018 SHALL transition IDLE->RUN, RUN->PAUSE and PAUSE->RUN on a start_stop press.
REQ-019 SHALL, on a clear press in IDLE or PAUSE, enter IDLE, pulse count_clr for one cycle and deassert lap_hold.
REQ-020 SHALL give clear priority when clear and start_stop presses occur in the same cycle; the start_stop press SHALL be discarded.
REQ-021 SHALL use a tick prescaler that counts 0..TICK_DIV-1 and wraps to 0 only in RUN, holds its value in PAUSE, and is forced to 0 in IDLE.
REQ-022 SHALL pulse count_en for one cycle when the prescaler is at TICK_DIV-1 in RUN, so that a resume completes the partial tick.
REQ-023 SHALL never assert count_en in IDLE or PAUSE, nor in the same cycle as count_clr.
REQ-024 SHALL advance scan_sel 0->1->2->3->0 once every SCAN_DIV cycles, in every state.

Reset
REQ-025 SHALL, while reset is low, force state=IDLE, running=0, count_en=0, count_clr=0, lap_hold=0, scan_sel=0, all prescalers, debounce counters and synchronizers=0.
REQ-026 SHALL, when reset is asserted mid-tick or mid-debounce, discard the partial count; no pulse SHALL be emitted on release of reset.

Configuration
REQ-027 SHALL compile the lap feature only when the macro STOPWATCH_LAP_EN is defined.
REQ-028 SHALL, with STOPWATCH_LAP_EN defined, toggle lap_hold on a clear press in RUN, with the state remaining RUN and count_en continuing uninterrupted.
REQ-029 SHALL, without STOPWATCH_LAP_EN, treat a clear press in RUN as a press in IDLE or PAUSE (enter IDLE, pulse count_clr), and tie lap_hold to 0.

Verification (DEB_CYCLES=4, TICK_DIV=10, SCAN_DIV=8)
REQ-030 SHALL cover reset then a start_stop press held 6 cycles -> state=01 and running=1, with count_en every 10 cycles thereafter.
REQ-031 SHALL cover a start_stop glitch of 3 cycles high -> no state change and count_en stays 0.
REQ-032 SHALL cover a pause after prescaler=6, idle 50 cycles, then resume -> first count_en 4 cycles after RUN re-entry.
REQ-033 SHALL cover clear and start_stop pressed simultaneously in PAUSE -> state=00, one count_clr pulse, no RUN.
REQ-034 SHALL cover a clear press in RUN -> with STOPWATCH_LAP_EN, lap_hold=1 and count_en continues; without it, state=00 and one count_clr pulse.
REQ-035 SHALL cover reset asserted at prescaler=9 in RUN -> all outputs 0 immediately, and no count_en after release.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// stopwatch_ctrl: control block for a stopwatch with start/stop and clear buttons.
// It synchronizes and debounces the raw buttons, runs the IDLE/RUN/PAUSE state
// machine, and produces the count tick and clear pulses for the time counter
// datapath, plus the display digit scan index.
// Optional lap feature: define STOPWATCH_LAP_EN so that a clear press in RUN
// toggles lap_hold instead of clearing. Without the macro, lap_hold is tied low.
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int TICK_DIV   = 1000000,
  parameter int SCAN_DIV   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic       count_en,
  output logic       count_clr,
  output logic       running,
  output logic [1:0] state,
  output logic [1:0] scan_sel,
  output logic       lap_hold
);

  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TICK_W = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int SCAN_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // Button lanes: bit 0 is start/stop, bit 1 is clear.
  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  logic [1:0]        btn_p0;
  logic [1:0]        btn_p1;
  logic [1:0]        btn_level;
  logic [1:0]        btn_press;
  logic [DEB_W-1:0]  deb_cnt [2];

  state_t            state_q;
  state_t            state_d;
  logic              clr_d;

  logic [TICK_W-1:0] tick_cnt;
  logic [SCAN_W-1:0] scan_cnt;

`ifdef STOPWATCH_LAP_EN
  logic              lap_tgl;
  logic              lap_q;
`endif

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_p0 <= 2'b00;
      btn_p1 <= 2'b00;
    end else begin
      btn_p0 <= {clear, start_stop};
      btn_p1 <= btn_p0;
    end
  end

  // Debounce: flip the accepted level only after DEB_CYCLES consecutive
  // disagreeing samples; a single agreeing sample restarts the count.
  // A press pulse is emitted only on the 0->1 flip.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_level <= 2'b00;
      btn_press <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        btn_press[i] <= 1'b0;
        if (btn_p1[i] != btn_level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            btn_level[i] <= btn_p1[i];
            btn_press[i] <= btn_p1[i];
            deb_cnt[i]   <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Next-state decode: clear outranks start/stop when both press together.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_tgl = 1'b0;
`endif
    if (btn_press[BTN_CLR]) begin
`ifdef STOPWATCH_LAP_EN
      if (state_q == ST_RUN) begin
        lap_tgl = 1'b1;
      end else begin
        state_d = ST_IDLE;
        clr_d   = 1'b1;
      end
`else
      state_d = ST_IDLE;
      clr_d   = 1'b1;
`endif
    end else if (btn_press[BTN_SS]) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register with registered running flag and clear pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      running   <= 1'b0;
      count_clr <= 1'b0;
    end else begin
      state_q   <= state_d;
      running   <= (state_d == ST_RUN);
      count_clr <= clr_d;
    end
  end

  // Tick prescaler: advances only while staying in RUN, so a pause keeps the
  // partial tick and the resume finishes it; leaving to IDLE zeroes it.
  // Because it only advances when the next state is RUN, count_en can never
  // coincide with a pause, an idle state, or a count_clr pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      count_en <= 1'b0;
    end else begin
      count_en <= 1'b0;
      if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          count_en <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end
      end else if (state_d == ST_IDLE) begin
        tick_cnt <= '0;
      end
    end
  end

  // Display scan: step the digit index once every SCAN_DIV cycles, always.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      scan_sel <= 2'b00;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_sel <= scan_sel + 2'b01;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Lap freeze flag: toggled by clear in RUN, dropped by any real clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_q <= 1'b0;
    end else if (clr_d) begin
      lap_q <= 1'b0;
    end else if (lap_tgl) begin
      lap_q <= ~lap_q;
    end
  end

  assign lap_hold = lap_q;
`else
  assign lap_hold = 1'b0;
`endif

  assign state = state_q;

endmodule
